// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, parity positions and the SECDED (15+1) encode function
package hamming_pkg;

    localparam int DATA_W = 11;
    localparam int CODE_W = 16;

    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P4 = 4;
    localparam int P8 = 8;

    localparam logic [CODE_W-1:0] MASK_P1 = 16'hAAAA;
    localparam logic [CODE_W-1:0] MASK_P2 = 16'hCCCC;
    localparam logic [CODE_W-1:0] MASK_P4 = 16'hF0F0;
    localparam logic [CODE_W-1:0] MASK_P8 = 16'hFF00;

    // Data goes to the non-power-of-two positions. Each Hamming bit covers the
    // positions with its index bit set. Bit 0 gives even parity over the word.
    function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] c;
        c        = '0;
        c[15:9]  = data[10:4];
        c[7:5]   = data[3:1];
        c[3]     = data[0];
        c[P1]    = ^(c & MASK_P1);
        c[P2]    = ^(c & MASK_P2);
        c[P4]    = ^(c & MASK_P4);
        c[P8]    = ^(c & MASK_P8);
        c[0]     = ^c[CODE_W-1:1];
        return c;
    endfunction

endpackage

// File: rtl/hamming_buf2.sv
// hamming_buf2: generic 2-entry valid/ready FIFO with registered-only ready
module hamming_buf2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    // Handshakes depend only on stored occupancy (and reset), never on out_ready for in_ready
    always_comb begin
        in_ready  = !rst && (cnt_q != 2'd2);
        out_valid = (cnt_q != 2'd0);
        out_data  = head_q;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next-state: head is the oldest word, tail only used when two are held
    always_comb begin
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        head_d = (pop && cnt_q == 2'd2)              ? tail_q  :
                 (push && (cnt_q == 2'd0 || pop))    ? in_data : head_q;
        tail_d = (push && cnt_q == 2'd1 && !pop)     ? in_data : tail_q;
    end

    // State registers; reset discards every buffered word
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/hamming_encoder.sv
// hamming_encoder: SECDED (15+1) encoder with 2-entry output buffer; HAMMING_ERR_INJECT_EN adds bit-flip injection
module hamming_encoder
    import hamming_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  dataIn,
    input  logic               inValid,
    output logic               inReady,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic               injEn,
    input  logic [3:0]         injLoc,
`endif
    output logic [CODE_W-1:0]  codeWord,
    output logic               outValid,
    input  logic               outReady,
    output logic [COUNT_W-1:0] wordCount
);

    logic [CODE_W-1:0]  enc_word;
    logic [COUNT_W-1:0] count_q, count_d;

    // Encode the incoming word; optionally invert one bit before it is stored
    always_comb begin
`ifdef HAMMING_ERR_INJECT_EN
        enc_word = hamming_encode(dataIn) ^ (injEn ? (CODE_W'(1) << injLoc) : '0);
`else
        enc_word = hamming_encode(dataIn);
`endif
    end

    hamming_buf2 #(.W(CODE_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_data   (enc_word),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .out_data  (codeWord),
        .out_valid (outValid),
        .out_ready (outReady)
    );

    // Delivered-word counter wraps silently
    always_comb begin
        count_d = count_q + COUNT_W'(outValid && outReady);
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign wordCount = count_q;

endmodule

// File: tb/tb_hamming_encoder.sv
// tb_hamming_encoder: directed and random checks of hamming_encoder (injection tests under HAMMING_ERR_INJECT_EN)
module tb_hamming_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] dataIn;
    logic        inValid;
    logic        inReady;
    logic [15:0] codeWord;
    logic        outValid;
    logic        outReady;
    logic [15:0] wordCount;
`ifdef HAMMING_ERR_INJECT_EN
    logic        injEn = 1'b0;
    logic [3:0]  injLoc = 4'd0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hamming_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .dataIn    (dataIn),
        .inValid   (inValid),
        .inReady   (inReady),
`ifdef HAMMING_ERR_INJECT_EN
        .injEn     (injEn),
        .injLoc    (injLoc),
`endif
        .codeWord  (codeWord),
        .outValid  (outValid),
        .outReady  (outReady),
        .wordCount (wordCount)
    );

    // Reference encoder: syndrome built from positions of set data bits
    function automatic logic [15:0] ref_enc(input logic [10:0] d);
        logic [15:0] c;
        logic [3:0]  s;
        c = '0;
        c[15:9] = d[10:4];
        c[7:5]  = d[3:1];
        c[3]    = d[0];
        s = '0;
        for (int i = 1; i < 16; i++) if (c[i]) s ^= 4'(i);
        c[1] = s[0];
        c[2] = s[1];
        c[4] = s[2];
        c[8] = s[3];
        c[0] = ^c[15:1];
        return c;
    endfunction

    // Reference decoder: returns corrected data; syn is the error location (0 if none)
    function automatic logic [10:0] ref_dec(input logic [15:0] c, output logic [3:0] syn);
        logic [15:0] w;
        syn = '0;
        for (int i = 1; i < 16; i++) if (c[i]) syn ^= 4'(i);
        w = c;
        if (syn != 0) w[syn] = ~w[syn];
        return {w[15:9], w[7:5], w[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [10:0] d, dec;
    logic [3:0]  syn;
    logic [15:0] exp_cnt;

    initial begin
        rst = 1'b1; inValid = 1'b0; outReady = 1'b0; dataIn = '0;
        tick(); tick();
        chk("rst_inReady", 32'(inReady), 32'd0);
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_codeWord", 32'(codeWord), 32'h0000);
        chk("rst_wordCount", 32'(wordCount), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_inReady", 32'(inReady), 32'd1);

        dataIn = 11'd2030; inValid = 1'b1; outReady = 1'b1;
        tick();
        inValid = 1'b0;
        chk("w2030_valid", 32'(outValid), 32'd1);
        chk("w2030_code", 32'(codeWord), 32'hFCF3);
        chk("w2030_cnt_before", 32'(wordCount), 32'd0);
        tick();
        chk("w2030_cnt_after", 32'(wordCount), 32'd1);
        chk("w2030_drained", 32'(outValid), 32'd0);

        dataIn = 11'h000; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        chk("w000_code", 32'(codeWord), 32'h0000);
        chk("w000_valid", 32'(outValid), 32'd1);
        tick();
        dataIn = 11'h7FF; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        chk("w7ff_code", 32'(codeWord), 32'hFFFF);
        tick();
        chk("cnt_3", 32'(wordCount), 32'd3);

        outReady = 1'b0; inValid = 1'b1; dataIn = 11'h001;
        tick();
        chk("bp_ready1", 32'(inReady), 32'd1);
        chk("bp_head1", 32'(codeWord), 32'h000F);
        dataIn = 11'h400;
        tick();
        chk("bp_full_ready", 32'(inReady), 32'd0);
        chk("bp_full_valid", 32'(outValid), 32'd1);
        chk("bp_hold_head", 32'(codeWord), 32'h000F);
        dataIn = 11'h123;
        tick();
        chk("bp_refused_hold", 32'(codeWord), 32'h000F);
        outReady = 1'b1;
        tick();
        chk("bp_order_second", 32'(codeWord), 32'h8117);
        chk("bp_ready_back", 32'(inReady), 32'd1);
        inValid = 1'b0;
        tick();
        chk("bp_drained", 32'(outValid), 32'd0);
        chk("bp_cnt", 32'(wordCount), 32'd5);

        exp_cnt = 16'd5;
        inValid = 1'b1; outReady = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            d = 11'($urandom_range(0, 2047));
            dataIn = d;
            tick();
            if (n > 0) exp_cnt++;
            chk("rnd_code", 32'(codeWord), 32'(ref_enc(d)));
            dec = ref_dec(codeWord, syn);
            chk("rnd_decode", 32'({syn, dec}), 32'({4'd0, d}));
        end
        inValid = 1'b0;
        tick();
        exp_cnt++;
        chk("rnd_cnt", 32'(wordCount), 32'(exp_cnt));
        chk("rnd_drained", 32'(outValid), 32'd0);

        outReady = 1'b0; inValid = 1'b1; dataIn = 11'h055;
        tick();
        dataIn = 11'h2AA;
        tick();
        chk("pre_rst_full", 32'(inReady), 32'd0);
        inValid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; outReady = 1'b1;
        chk("mid_rst_valid", 32'(outValid), 32'd0);
        chk("mid_rst_cnt", 32'(wordCount), 32'd0);
        tick(); tick();
        chk("mid_rst_no_emit", 32'(outValid), 32'd0);
        chk("mid_rst_cnt_stay", 32'(wordCount), 32'd0);

`ifdef HAMMING_ERR_INJECT_EN
        dataIn = 11'd2030; inValid = 1'b1; injEn = 1'b1; injLoc = 4'd5;
        tick();
        injEn = 1'b0; inValid = 1'b0;
        chk("inj_code", 32'(codeWord), 32'hFCD3);
        dec = ref_dec(codeWord, syn);
        chk("inj_loc", 32'(syn), 32'd5);
        chk("inj_data", 32'(dec), 32'd2030);
        tick();
        chk("inj_cnt", 32'(wordCount), 32'd1);
        dataIn = 11'd2030; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        chk("inj_once", 32'(codeWord), 32'hFCF3);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hamming_encoder.md
# hamming_encoder

Hamming (15+1) SECDED encoder: takes 11-bit data words over a valid/ready handshake, produces 16-bit codewords (4 Hamming parity bits plus 1 overall parity bit) that the Hamming decoder accepts directly. It sits on the transmit side of the channel, and its output buffer decouples channel back-pressure from the data source. A wrap-around counter reports delivered words.

## Interface
- COUNT_W, 16, width of the delivered-word counter
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- dataIn  in  11  data word to encode
- inValid  in  1  dataIn is valid
- inReady  out  1  encoder can accept a word this cycle
- codeWord  out  16  encoded word at the head of the output buffer
- outValid  out  1  codeWord is valid
- outReady  in  1  sink accepts codeWord this cycle
- wordCount  out  COUNT_W  number of output handshakes since reset, modulo 2^COUNT_W

## Operation
- Bit layout (position = bit index):
  - Data bits: dataIn[10:4] map to codeWord[15:9]; dataIn[3:1] map to codeWord[7:5]; dataIn[0] maps to codeWord[3].
  - Hamming parity bits: codeWord[1], [2], [4], [8]. The parity bit at position 2^k is the XOR of all data bits whose position has bit k set. This makes the XOR of the positions of all ones in bits 15:1 equal zero.
  - Overall parity: codeWord[0] is the XOR of codeWord[15:1], giving even parity over all 16 bits.
- Input handshake fires when inValid && inReady. The word is encoded combinationally and written into a 2-entry FIFO output buffer.
- inReady = (occupancy < 2). It is registered-state derived only, with no combinational path from outReady.
- Output handshake fires when outValid && outReady. The head entry is popped and wordCount increments.
- outValid = (occupancy > 0). codeWord shows the head entry and holds stable while outValid && !outReady.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - Order is preserved.
  - This can only happen at occupancy 1, since a push is refused at occupancy 2.
- At occupancy 0, a word is never passed through combinationally; it always goes through the buffer.
- wordCount wraps from 2^COUNT_W−1 to 0 with no flag.
- inValid is ignored while inReady is low.

## Timing
- Reset values: inReady=0 during the reset cycle and 1 in the first cycle after; outValid=0; codeWord=16'h0000; wordCount=0; occupancy=0.
- Reset asserted mid-operation discards all buffered words on the next edge.
- Latency: a word accepted at edge N is presented with outValid=1 from edge N onward (one register stage).
- Throughput: one word per cycle sustained while outReady=1.
- With outReady held low: two words are accepted, then inReady drops on the edge that stores the second word.

## Configuration
- HAMMING_ERR_INJECT_EN, when defined:
  - Adds the ports injEn (in, 1) and injLoc (in, 4).
  - On an input handshake with injEn=1, bit injLoc of the encoded word is inverted before it is stored. injLoc=0 flips the overall parity bit.
  - Injection affects only that word; wordCount is unaffected.
- Without the macro: the ports do not exist and codewords are never modified.

## Structure
- hamming_pkg holds:
  - DATA_W=11 and CODE_W=16
  - the parity position constants 1, 2, 4, 8
  - a function hamming_encode(data) returning the 16-bit codeword
- Sub-module hamming_buf2: a generic 2-entry valid/ready FIFO, parameterized on width, containing the occupancy state, ordering, and reset behaviour.

## Test plan
- Reset, then dataIn=11'd2030 with one handshake and outReady=1 → next cycle codeWord=16'hFCF3, outValid=1, wordCount=1 after the pop.
- dataIn=11'h000 → 16'h0000; dataIn=11'h7FF → 16'hFFFF.
- outReady=0 with inValid held → two words accepted, inReady=0, outValid=1. Then outReady=1 → words emerge in push order and inReady returns on the next cycle.
- Push and pop every cycle for 1000 random words → each codeWord equals the package encode function, and feeding it to the decoder returns the original data.
- Assert rst with 2 words buffered → next cycle outValid=0, wordCount=0, and the buffered words are never emitted.
- With HAMMING_ERR_INJECT_EN, data 2030, injLoc=5 → codeWord=16'hFCD3; the decoder reports an error at location 5 and recovers 2030.
